// File: rtl/relax_seq.sv
// Edge-relaxation sequencer: new_dist = min(dist_u + weight, dist_v).
// It issues an unsigned ADD and then an unsigned MIN on a shared external combinational ALU.
module relax_seq #(
  parameter logic [31:0] INF_VAL = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      dist_u,
  input  logic [31:0]      weight,
  input  logic [31:0]      dist_v,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             busy,
  output logic             done,
  output logic [31:0]      new_dist,
  output logic             updated,
  output logic [CNT_W-1:0] relax_count
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_MIN, S_DONE} state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_MIN_U = 4'b1101;

  state_t             state_q, state_d;
  logic [31:0]        du_q, du_d, w_q, w_d, dv_q, dv_d, sum_q, sum_d;
  logic [31:0]        new_dist_q, new_dist_d;
  logic               updated_q, updated_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d       = state_q;
    du_d          = du_q;
    w_d           = w_q;
    dv_d          = dv_q;
    sum_d         = sum_q;
    new_dist_d    = new_dist_q;
    updated_d     = updated_q;
    cnt_d         = cnt_q;
    alu_op        = OP_ADD;
    alu_operand_a = '0;
    alu_operand_b = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          du_d = dist_u;
          w_d  = weight;
          dv_d = dist_v;
          if (dist_u == INF_VAL) begin
            // Unreachable source: the result is dist_v and both ALU passes are skipped
            new_dist_d = dist_v;
            updated_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        alu_op        = OP_ADD;
        alu_operand_a = du_q;
        alu_operand_b = w_q;
        // A wrapped sum is smaller than the addend, so it saturates to INF_VAL
        sum_d   = (alu_result < du_q) ? INF_VAL : alu_result;
        state_d = S_MIN;
      end
      S_MIN: begin
        alu_op        = OP_MIN_U;
        alu_operand_a = sum_q;
        alu_operand_b = dv_q;
        new_dist_d    = alu_result;
        updated_d     = (alu_result != dv_q);
        // The count is updated as DONE is entered, so it is already valid while done is high
        if (updated_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      du_q       <= '0;
      w_q        <= '0;
      dv_q       <= '0;
      sum_q      <= '0;
      new_dist_q <= '0;
      updated_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      du_q       <= du_d;
      w_q        <= w_d;
      dv_q       <= dv_d;
      sum_q      <= sum_d;
      new_dist_q <= new_dist_d;
      updated_q  <= updated_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign new_dist    = new_dist_q;
  assign updated     = updated_q;
  assign relax_count = cnt_q;

endmodule
